// File: rtl/cq_pkg.sv
// Shared definitions for the circular queue `cq` and its write-side arbiter.
//   owner_t      : write-port ownership state used by cq_wr_arb
//   CQ_DW        : queue data width
//   CQ_DEPTH     : physical queue entries (one slot is kept empty, so 7 usable)
//   CQ_BURST_DEF : default per-grant burst limit
package cq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  localparam int CQ_DW        = 16;
  localparam int CQ_DEPTH     = 8;
  localparam int CQ_BURST_DEF = 4;

endpackage

// File: rtl/burst_ctr.sv
// Counts transfers made during the current write-port grant.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low clear
//   clr   : synchronous clear (wins over inc)
//   inc   : a transfer happens this cycle
//   hit   : this transfer is the last one allowed in the burst
module burst_ctr #(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [2:0] count;
  logic [3:0] count_inc;

  // One extra bit so count+1 cannot wrap before comparing with BURST.
  assign count_inc = {1'b0, count} + 4'd1;
  assign hit       = inc && (count_inc == 4'(BURST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc[2:0];
    end
  end

endmodule

// File: rtl/cq_wr_arb.sv
// Two-producer write arbiter for the circular queue `cq`.
// Round-robin ownership of the single write port with a per-grant burst
// limit. Outputs are combinational from the registered owner, so a request
// is granted one cycle after it is first seen.
// Ports:
//   clk, reset             : clock and asynchronous active-low reset
//   req0_valid/data/ready  : producer 0 handshake
//   req1_valid/data/ready  : producer 1 handshake
//   cq_full                : queue full flag
//   cq_wr, cq_din          : queue write strobe and data
//   grant                  : one-hot current owner, 2'b00 when idle
module cq_wr_arb
  import cq_pkg::*;
#(
  parameter int DW    = CQ_DW,
  parameter int BURST = CQ_BURST_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          cq_full,
  output logic          cq_wr,
  output logic [DW-1:0] cq_din,
  output logic [1:0]    grant
);

  owner_t owner, owner_n;
  logic   last, last_n;     // 0: producer 0 was granted last, 1: producer 1
  logic   ctr_clr;
  logic   hit;

  assign req0_ready = (owner == OWN0) && req0_valid && !cq_full;
  assign req1_ready = (owner == OWN1) && req1_valid && !cq_full;
  assign cq_wr      = req0_ready || req1_ready;
  assign grant      = {owner == OWN1, owner == OWN0};

  always_comb begin
    cq_din = '0;
    if (owner == OWN0) begin
      cq_din = req0_data;
    end else if (owner == OWN1) begin
      cq_din = req1_data;
    end
  end

  burst_ctr #(.BURST(BURST)) u_burst_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .inc   (cq_wr),
    .hit   (hit)
  );

  // A full queue only stalls the owner; release happens solely when the
  // owner drops valid or exhausts its burst.
  always_comb begin
    owner_n = owner;
    last_n  = last;
    ctr_clr = 1'b0;
    unique case (owner)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          owner_n = last ? OWN0 : OWN1;
          last_n  = ~last;
          ctr_clr = 1'b1;
        end else if (req0_valid) begin
          owner_n = OWN0;
          last_n  = 1'b0;
          ctr_clr = 1'b1;
        end else if (req1_valid) begin
          owner_n = OWN1;
          last_n  = 1'b1;
          ctr_clr = 1'b1;
        end
      end
      OWN0: begin
        if (req0_valid) begin
          if (hit) begin
            ctr_clr = 1'b1;
            if (req1_valid) begin
              owner_n = OWN1;
              last_n  = 1'b1;
            end
          end
        end else begin
          ctr_clr = 1'b1;
          if (req1_valid) begin
            owner_n = OWN1;
            last_n  = 1'b1;
          end else begin
            owner_n = IDLE;
          end
        end
      end
      OWN1: begin
        if (req1_valid) begin
          if (hit) begin
            ctr_clr = 1'b1;
            if (req0_valid) begin
              owner_n = OWN0;
              last_n  = 1'b0;
            end
          end
        end else begin
          ctr_clr = 1'b1;
          if (req0_valid) begin
            owner_n = OWN0;
            last_n  = 1'b0;
          end else begin
            owner_n = IDLE;
          end
        end
      end
      default: begin
        owner_n = IDLE;
        ctr_clr = 1'b1;
      end
    endcase
  end

  // last resets to producer 1 so producer 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= IDLE;
      last  <= 1'b1;
    end else begin
      owner <= owner_n;
      last  <= last_n;
    end
  end

endmodule

// File: tb/tb_cq_wr_arb.sv
module tb_cq_wr_arb;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        cq_full, cq_wr;
  logic [15:0] cq_din;
  logic [1:0]  grant;

  // Queue occupancy model: 7 usable entries, optional forced full.
  logic [3:0]  occ;
  logic        rd_en, rd, hold_full;

  int n_cmp = 0;
  int n_err = 0;

  cq_wr_arb dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .cq_full    (cq_full),
    .cq_wr      (cq_wr),
    .cq_din     (cq_din),
    .grant      (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd      = rd_en && (occ != 4'd0);
  assign cq_full = (occ == 4'd7) || hold_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ <= 4'd0;
    else        occ <= occ + (cq_wr ? 4'd1 : 4'd0) - (rd ? 4'd1 : 4'd0);
  end

  task automatic do_reset;
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
    rd_en = 0; hold_full = 0;
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset;
    reset = 0; rd_en = 0; hold_full = 0;
    req0_valid = 1; req1_valid = 1; req0_data = 16'hAAAA; req1_data = 16'h5555;
    @(negedge clk); #1;
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got=%b exp=00", grant); end
    n_cmp++; if (cq_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got=%b exp=0", cq_wr); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    n_cmp++; if (cq_din !== 16'h0000) begin n_err++; $display("FAIL reset_din got=%h exp=0000", cq_din); end
    @(negedge clk); #1;
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_hold_grant got=%b exp=00", grant); end
  endtask

  task automatic test_fill;
    logic [15:0] d0;
    do_reset;
    d0 = 16'h0001;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      req0_valid = 1; req0_data = d0;
      #1;
      if (c == 0) begin
        n_cmp++; if (grant !== 2'b00 || cq_wr !== 1'b0) begin n_err++; $display("FAIL fill_c0 grant=%b wr=%b exp 00/0", grant, cq_wr); end
      end else if (c <= 7) begin
        n_cmp++; if (grant !== 2'b01 || cq_wr !== 1'b1) begin n_err++; $display("FAIL fill_wr c=%0d grant=%b wr=%b exp 01/1", c, grant, cq_wr); end
        n_cmp++; if (cq_din !== 16'(c)) begin n_err++; $display("FAIL fill_din c=%0d got=%h exp=%h", c, cq_din, 16'(c)); end
      end else begin
        n_cmp++; if (cq_full !== 1'b1 || req0_ready !== 1'b0 || cq_wr !== 1'b0 || grant !== 2'b01) begin
          n_err++; $display("FAIL fill_full c=%0d full=%b ready=%b wr=%b grant=%b exp 1/0/0/01", c, cq_full, req0_ready, cq_wr, grant);
        end
      end
      if (req0_ready) d0++;
    end
  endtask

  task automatic test_tie;
    logic [15:0] d0, d1, exp_din;
    logic [1:0]  exp_g;
    do_reset;
    rd_en = 1; d0 = 16'h0100; d1 = 16'h0200;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      req0_valid = 1; req1_valid = 1; req0_data = d0; req1_data = d1;
      #1;
      if (c == 0)      begin exp_g = 2'b00; exp_din = 16'h0000; end
      else if (c <= 4) begin exp_g = 2'b01; exp_din = 16'h0100 + 16'(c - 1); end
      else if (c <= 8) begin exp_g = 2'b10; exp_din = 16'h0200 + 16'(c - 5); end
      else             begin exp_g = 2'b01; exp_din = 16'h0104; end
      n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL tie_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
      n_cmp++; if (cq_wr !== (c != 0)) begin n_err++; $display("FAIL tie_wr c=%0d got=%b exp=%b", c, cq_wr, c != 0); end
      n_cmp++; if (cq_din !== exp_din) begin n_err++; $display("FAIL tie_din c=%0d got=%h exp=%h", c, cq_din, exp_din); end
      if (req0_ready) d0++;
      if (req1_ready) d1++;
    end
  endtask

  task automatic test_release;
    logic [15:0] d0, d1, exp_din;
    logic [1:0]  exp_g;
    logic        exp_wr;
    do_reset;
    rd_en = 1; d0 = 16'h0400; d1 = 16'h0500;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      req0_valid = (c >= 2); req1_valid = (c != 3);
      req0_data = d0; req1_data = d1;
      #1;
      exp_wr = 1'b1;
      if (c == 0)      begin exp_g = 2'b00; exp_din = 16'h0000; exp_wr = 1'b0; end
      else if (c <= 2) begin exp_g = 2'b10; exp_din = 16'h0500 + 16'(c - 1); end
      else if (c == 3) begin exp_g = 2'b10; exp_din = 16'h0502; exp_wr = 1'b0; end
      else if (c <= 7) begin exp_g = 2'b01; exp_din = 16'h0400 + 16'(c - 4); end
      else             begin exp_g = 2'b10; exp_din = 16'h0502; end
      n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL rel_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
      n_cmp++; if (cq_wr !== exp_wr) begin n_err++; $display("FAIL rel_wr c=%0d got=%b exp=%b", c, cq_wr, exp_wr); end
      n_cmp++; if (cq_din !== exp_din) begin n_err++; $display("FAIL rel_din c=%0d got=%h exp=%h", c, cq_din, exp_din); end
      if (req0_ready) d0++;
      if (req1_ready) d1++;
    end
  endtask

  task automatic test_full_stall;
    logic [15:0] d0, d1, exp_din;
    logic [1:0]  exp_g;
    logic        exp_wr;
    do_reset;
    rd_en = 1; d0 = 16'h0301; d1 = 16'h0600;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      req0_valid = 1; req1_valid = (c >= 3);
      hold_full = (c >= 3 && c <= 7);
      req0_data = d0; req1_data = d1;
      #1;
      exp_wr = 1'b1;
      if (c == 0)      begin exp_g = 2'b00; exp_din = 16'h0000; exp_wr = 1'b0; end
      else if (c <= 2) begin exp_g = 2'b01; exp_din = 16'h0301 + 16'(c - 1); end
      else if (c <= 7) begin exp_g = 2'b01; exp_din = 16'h0303; exp_wr = 1'b0; end
      else if (c <= 9) begin exp_g = 2'b01; exp_din = 16'h0303 + 16'(c - 8); end
      else             begin exp_g = 2'b10; exp_din = 16'h0600; end
      n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL stall_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
      n_cmp++; if (cq_wr !== exp_wr) begin n_err++; $display("FAIL stall_wr c=%0d got=%b exp=%b", c, cq_wr, exp_wr); end
      n_cmp++; if (cq_din !== exp_din) begin n_err++; $display("FAIL stall_din c=%0d got=%h exp=%h", c, cq_din, exp_din); end
      if (req0_ready) d0++;
      if (req1_ready) d1++;
    end
    hold_full = 0;
  endtask

  task automatic test_no_contender;
    logic [15:0] d0;
    do_reset;
    rd_en = 1; d0 = 16'h0700;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      req0_valid = 1; req0_data = d0;
      #1;
      if (c == 0) begin
        n_cmp++; if (grant !== 2'b00 || cq_wr !== 1'b0) begin n_err++; $display("FAIL solo_c0 grant=%b wr=%b exp 00/0", grant, cq_wr); end
      end else begin
        n_cmp++; if (grant !== 2'b01 || cq_wr !== 1'b1) begin n_err++; $display("FAIL solo_wr c=%0d grant=%b wr=%b exp 01/1", c, grant, cq_wr); end
        n_cmp++; if (cq_din !== 16'h0700 + 16'(c - 1)) begin n_err++; $display("FAIL solo_din c=%0d got=%h exp=%h", c, cq_din, 16'h0700 + 16'(c - 1)); end
      end
      if (req0_ready) d0++;
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    rd_en = 1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      req1_valid = 1; req1_data = 16'h0800 + 16'(c > 0 ? c - 1 : 0);
      #1;
    end
    n_cmp++; if (grant !== 2'b10 || req1_ready !== 1'b1 || cq_wr !== 1'b1) begin
      n_err++; $display("FAIL arst_pre grant=%b ready1=%b wr=%b exp 10/1/1", grant, req1_ready, cq_wr);
    end
    #2 reset = 0;
    #1;
    n_cmp++; if (cq_wr !== 1'b0) begin n_err++; $display("FAIL arst_wr got=%b exp=0", cq_wr); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL arst_grant got=%b exp=00", grant); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL arst_ready1 got=%b exp=0", req1_ready); end
    @(negedge clk);
    reset = 1; req0_valid = 1; req1_valid = 1; req0_data = 16'h0900;
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL arst_rel_grant got=%b exp=00", grant); end
    @(negedge clk); #1;
    n_cmp++; if (grant !== 2'b01 || cq_wr !== 1'b1) begin n_err++; $display("FAIL arst_tie grant=%b wr=%b exp 01/1", grant, cq_wr); end
    n_cmp++; if (cq_din !== 16'h0900) begin n_err++; $display("FAIL arst_din got=%h exp=0900", cq_din); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fill;
    test_tie;
    test_release;
    test_full_stall;
    test_no_contender;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
